// File: rtl/fetch_if.sv
// Fetch stage bus: instruction-memory port, control inputs and IF/ID outputs.
// The fetch stage uses the master modport; its environment uses slave.
interface fetch_if #(
    parameter int N     = 64,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             redirect;
    logic [N-1:0]     redirect_target;
    logic [N-1:0]     imem_addr;
    logic [31:0]      imem_data;
    logic [N-1:0]     if_pc;
    logic [31:0]      if_instr;
    logic             if_valid;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_target, imem_data,
        output imem_addr, if_pc, if_instr, if_valid, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_target, imem_data,
        input  imem_addr, if_pc, if_instr, if_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// saturating count of instructions latched. Priority: reset > redirect > stall.
module fetch_stage #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           CNT_W    = 32
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);

    logic [N-1:0]     r_pc;
    logic [N-1:0]     r_if_pc;
    logic [31:0]      r_if_instr;
    logic             r_if_valid;
    logic [CNT_W-1:0] r_fetch_count;

    logic             w_cnt_sat;

    assign w_cnt_sat = (r_fetch_count == {CNT_W{1'b1}});

    // NOTE: reset is sampled inside the clocked block (synchronous); all state
    // uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_pc       <= '0;
            r_if_instr    <= '0;
            r_if_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else if (bus.redirect) begin
            // Redirect wins over stall and inserts a bubble; low bits word-aligned.
            r_pc          <= {bus.redirect_target[N-1:2], 2'b00};
            r_if_pc       <= '0;
            r_if_instr    <= '0;
            r_if_valid    <= 1'b0;
        end else if (!bus.stall) begin
            r_pc          <= r_pc + N'(4);
            r_if_pc       <= r_pc;
            r_if_instr    <= bus.imem_data;
            r_if_valid    <= 1'b1;
            if (!w_cnt_sat) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.if_pc       = r_if_pc;
    assign bus.if_instr    = r_if_instr;
    assign bus.if_valid    = r_if_valid;
    assign bus.fetch_count = r_fetch_count;

endmodule
